// File: rtl/seg7_scan_display_if.sv
// Display port bundle: scan tick and adder result in, multiplexed segment/anode drive out.
// Master drives the tick and the sum strobe; the display (slave) drives Seg/An/Frame_done.
interface seg7_scan_display_if #(
    parameter int SUM_W = 5
);
    logic             i_tick;
    logic [SUM_W-1:0] i_sum;
    logic             i_sum_vld;
    logic [6:0]       o_seg;
    logic [1:0]       o_an;
    logic             o_frame_done;

    modport master (
        output i_tick, i_sum, i_sum_vld,
        input  o_seg, o_an, o_frame_done
    );

    modport slave (
        input  i_tick, i_sum, i_sum_vld,
        output o_seg, o_an, o_frame_done
    );
endinterface

// File: rtl/seg7_scan_display.sv
// 2-digit scanned 7-seg driver, one digit per tick edge; outputs registered one clock after idx moves.
// No backpressure: sums are latched only at frame start. Optional LEAD_ZERO_BLANK_EN blanks a tens 0.
module seg7_scan_display #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                i_clo,
    input  logic                i_rst,
    seg7_scan_display_if.slave  io_bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_UNITS = 2'd1,
        ST_TENS  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [1:0] AN_OFF  = ACTIVE_LOW ? 2'b11 : 2'b00;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_tick_q;
    logic [4:0]  r_disp_val;
    logic [4:0]  r_pending;
    logic        r_pend_flag;
    logic [6:0]  r_seg;
    logic [1:0]  r_an;
    logic        r_frame_done;

    logic        w_step;
    logic        w_load;
    logic        w_frame_done_nxt;
    logic [1:0]  w_tens;
    logic [3:0]  w_units;
    logic [6:0]  w_seg_ah;
    logic [1:0]  w_an_ah;

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0:    f_seg = 7'h3F;
            4'd1:    f_seg = 7'h06;
            4'd2:    f_seg = 7'h5B;
            4'd3:    f_seg = 7'h4F;
            4'd4:    f_seg = 7'h66;
            4'd5:    f_seg = 7'h6D;
            4'd6:    f_seg = 7'h7D;
            4'd7:    f_seg = 7'h07;
            4'd8:    f_seg = 7'h7F;
            4'd9:    f_seg = 7'h6F;
            default: f_seg = 7'h00;
        endcase
    endfunction

    assign w_step = io_bus.i_tick & ~r_tick_q;

    always_ff @(posedge i_clo or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_load           = 1'b0;
        w_frame_done_nxt = 1'b0;
        if (w_step) begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_UNITS;
                    w_load      = 1'b1;
                end
                ST_UNITS: begin
                    w_state_nxt = ST_TENS;
                end
                ST_TENS: begin
                    w_state_nxt      = ST_UNITS;
                    w_frame_done_nxt = 1'b1;
                    w_load           = 1'b1;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // A strobe coinciding with the frame-start load goes straight to the display.
    always_ff @(posedge i_clo or posedge i_rst) begin
        if (i_rst) begin
            r_tick_q     <= 1'b0;
            r_disp_val   <= 5'd0;
            r_pending    <= 5'd0;
            r_pend_flag  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_tick_q     <= io_bus.i_tick;
            r_frame_done <= w_frame_done_nxt;
            if (io_bus.i_sum_vld) begin
                r_pending <= io_bus.i_sum;
            end
            if (w_load) begin
                r_pend_flag <= 1'b0;
                if (io_bus.i_sum_vld) begin
                    r_disp_val <= io_bus.i_sum;
                end else if (r_pend_flag) begin
                    r_disp_val <= r_pending;
                end
            end else if (io_bus.i_sum_vld) begin
                r_pend_flag <= 1'b1;
            end
        end
    end

    always_comb begin
        w_tens  = 2'd0;
        w_units = r_disp_val[3:0];
        if (r_disp_val >= 5'd30) begin
            w_tens  = 2'd3;
            w_units = 4'(r_disp_val - 5'd30);
        end else if (r_disp_val >= 5'd20) begin
            w_tens  = 2'd2;
            w_units = 4'(r_disp_val - 5'd20);
        end else if (r_disp_val >= 5'd10) begin
            w_tens  = 2'd1;
            w_units = 4'(r_disp_val - 5'd10);
        end
    end

    always_comb begin
        w_seg_ah = 7'h00;
        w_an_ah  = 2'b00;
        case (r_state)
            ST_UNITS: begin
                w_seg_ah = f_seg(w_units);
                w_an_ah  = 2'b01;
            end
            ST_TENS: begin
                w_seg_ah = f_seg({2'b00, w_tens});
                w_an_ah  = 2'b10;
`ifdef LEAD_ZERO_BLANK_EN
                if (w_tens == 2'd0) begin
                    w_seg_ah = 7'h00;
                end
`endif
            end
            default: begin
                w_seg_ah = 7'h00;
                w_an_ah  = 2'b00;
            end
        endcase
    end

    always_ff @(posedge i_clo or posedge i_rst) begin
        if (i_rst) begin
            r_seg <= SEG_OFF;
            r_an  <= AN_OFF;
        end else begin
            r_seg <= ACTIVE_LOW ? ~w_seg_ah : w_seg_ah;
            r_an  <= ACTIVE_LOW ? ~w_an_ah  : w_an_ah;
        end
    end

    assign io_bus.o_seg        = r_seg;
    assign io_bus.o_an         = r_an;
    assign io_bus.o_frame_done = r_frame_done;
endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for the 2-digit scanned display, ACTIVE_LOW=1, all expectations hand-computed.
module tb_seg7_scan_display;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    int   fd_cnt;

`ifdef LEAD_ZERO_BLANK_EN
    localparam logic [6:0] TENS_ZERO = 7'h7F;
`else
    localparam logic [6:0] TENS_ZERO = 7'h40;
`endif

    seg7_scan_display_if #(.SUM_W(5)) bus ();

    seg7_scan_display #(.ACTIVE_LOW(1'b1)) dut (
        .i_clo  (clk),
        .i_rst  (rst),
        .io_bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [4:0] v);
        bus.i_sum     = v;
        bus.i_sum_vld = 1'b1;
        step_clk();
        bus.i_sum_vld = 1'b0;
    endtask

    // One-cycle tick; fd returns Frame_done seen after the stepping edge.
    task automatic tick_pulse(output logic fd);
        bus.i_tick = 1'b1;
        step_clk();
        bus.i_tick = 1'b0;
        fd = bus.o_frame_done;
        step_clk();
    endtask

    task automatic chk(input string name, input logic [6:0] act_seg, input logic [6:0] exp_seg,
                       input logic [1:0] act_an, input logic [1:0] exp_an);
        n_vec++;
        if (act_seg !== exp_seg || act_an !== exp_an) begin
            n_err++;
            $display("FAIL %s: seg=%h an=%b, expected seg=%h an=%b", name, act_seg, act_an, exp_seg, exp_an);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step_clk();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            repeat (7) step_clk();
            n_vec++;
            if (bus.o_seg !== 7'h7F || bus.o_an !== 2'b11 || bus.o_frame_done !== 1'b0) begin
                n_err++;
                $display("FAIL reset_idle[%0d]: seg=%h an=%b fd=%b, expected 7f 11 0",
                         i, bus.o_seg, bus.o_an, bus.o_frame_done);
            end
        end
    endtask

    task automatic test_basic_scan();
        logic fd;
        strobe(5'd23);
        tick_pulse(fd);
        chk("first_units", bus.o_seg, 7'h30, bus.o_an, 2'b10);
        n_vec++;
        if (fd !== 1'b0) begin
            n_err++;
            $display("FAIL first_step_fd: got %b, expected 0", fd);
        end
        tick_pulse(fd);
        chk("first_tens", bus.o_seg, 7'h24, bus.o_an, 2'b01);
        tick_pulse(fd);
        n_vec++;
        if (fd !== 1'b1 || bus.o_frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_fd: pulse=%b after=%b, expected 1 then 0", fd, bus.o_frame_done);
        end
        chk("wrap_units", bus.o_seg, 7'h30, bus.o_an, 2'b10);
    endtask

    task automatic test_held_tick();
        for (int pass = 0; pass < 2; pass++) begin
            fd_cnt     = 0;
            bus.i_tick = 1'b1;
            for (int i = 0; i < 10; i++) begin
                step_clk();
                if (bus.o_frame_done === 1'b1) fd_cnt++;
            end
            bus.i_tick = 1'b0;
            step_clk();
            if (bus.o_frame_done === 1'b1) fd_cnt++;
            n_vec++;
            if (fd_cnt != pass) begin
                n_err++;
                $display("FAIL held_fd_count[%0d]: got %0d, expected %0d", pass, fd_cnt, pass);
            end
            if (pass == 0) chk("held_to_tens", bus.o_seg, 7'h24, bus.o_an, 2'b01);
            else           chk("held_to_units", bus.o_seg, 7'h30, bus.o_an, 2'b10);
        end
    endtask

    task automatic test_pending();
        logic fd;
        strobe(5'd31);
        tick_pulse(fd);
        chk("pend_tens_old", bus.o_seg, 7'h24, bus.o_an, 2'b01);
        tick_pulse(fd);
        chk("pend_units_new", bus.o_seg, 7'h79, bus.o_an, 2'b10);
        tick_pulse(fd);
        chk("pend_tens_new", bus.o_seg, 7'h30, bus.o_an, 2'b01);
    endtask

    task automatic test_bypass_lead_zero();
        logic fd;
        strobe(5'd12);
        bus.i_tick    = 1'b1;
        bus.i_sum     = 5'd7;
        bus.i_sum_vld = 1'b1;
        step_clk();
        bus.i_tick    = 1'b0;
        bus.i_sum_vld = 1'b0;
        step_clk();
        chk("bypass_units", bus.o_seg, 7'h78, bus.o_an, 2'b10);
        tick_pulse(fd);
        chk("lead_zero_tens", bus.o_seg, TENS_ZERO, bus.o_an, 2'b01);
        tick_pulse(fd);
        chk("bypass_no_pend", bus.o_seg, 7'h78, bus.o_an, 2'b10);
        tick_pulse(fd);
    endtask

    task automatic test_decode_table();
        logic [4:0] vals [6];
        logic [6:0] exp_u [6];
        logic [6:0] exp_t [6];
        logic       fd;
        vals  = '{5'd0, 5'd9, 5'd10, 5'd19, 5'd30, 5'd31};
        exp_u = '{7'h40, 7'h10, 7'h40, 7'h10, 7'h40, 7'h79};
        exp_t = '{TENS_ZERO, TENS_ZERO, 7'h79, 7'h79, 7'h30, 7'h30};
        for (int i = 0; i < 6; i++) begin
            strobe(vals[i]);
            tick_pulse(fd);
            chk($sformatf("dec_units_%0d", vals[i]), bus.o_seg, exp_u[i], bus.o_an, 2'b10);
            tick_pulse(fd);
            chk($sformatf("dec_tens_%0d", vals[i]), bus.o_seg, exp_t[i], bus.o_an, 2'b01);
        end
    endtask

    task automatic test_async_reset();
        logic fd;
        tick_pulse(fd);
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (bus.o_seg !== 7'h7F || bus.o_an !== 2'b11 || bus.o_frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: seg=%h an=%b fd=%b, expected 7f 11 0",
                     bus.o_seg, bus.o_an, bus.o_frame_done);
        end
        step_clk();
        rst = 1'b0;
        repeat (3) step_clk();
        chk("post_reset_idle", bus.o_seg, 7'h7F, bus.o_an, 2'b11);
        tick_pulse(fd);
        chk("restart_units", bus.o_seg, 7'h40, bus.o_an, 2'b10);
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        rst           = 1'b1;
        bus.i_tick    = 1'b0;
        bus.i_sum     = 5'd0;
        bus.i_sum_vld = 1'b0;
        test_reset();
        test_basic_scan();
        test_held_tick();
        test_pending();
        test_bypass_lead_zero();
        test_decode_table();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
